vibrate_p2p_detect: RTL and testbench



---
 rtl/vibrate_p2p_detect.sv | 152 +++++++++++++++
 tb/tb_vibrate_p2p_detect.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vibrate_p2p_detect.sv
// Four-channel window peak-to-peak detector with window-count alarm hysteresis.
// Each channel is an identical lane; the top only packs ports and ORs the alarms.

module vibrate_p2p_lane #(
  parameter int          WIN_LEN  = 64,
  parameter logic [15:0] THRESH   = 16'd200,
  parameter int          HOLD_CNT = 3,
  parameter int          CLR_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] p2p,
  output logic        p2p_valid,
  output logic        alarm
);
  localparam int         CW    = $clog2(WIN_LEN) + 1;
  localparam logic [3:0] HOLD4 = 4'(HOLD_CNT);
  localparam logic [3:0] CLR4  = 4'(CLR_CNT);

  logic [3:0]    e;
  logic [CW-1:0] cnt;
  logic [15:0]   mn, mx, lo, hi, p;
  logic [3:0]    over_cnt, under_cnt, over_nxt, under_nxt;
  logic          strobe, last;

  // Data trails its enable by two cycles upstream; strobe on the delayed rising edge.
  assign strobe = e[2] & ~e[3];
  assign last   = (cnt == CW'(WIN_LEN - 1));

  always_comb begin
    lo = din;
    hi = din;
    if (cnt != '0) begin
      lo = (din < mn) ? din : mn;
      hi = (din > mx) ? din : mx;
    end
  end

  assign p         = hi - lo;
  assign over_nxt  = (over_cnt  == 4'd15) ? 4'd15 : over_cnt  + 4'd1;
  assign under_nxt = (under_cnt == 4'd15) ? 4'd15 : under_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e         <= '0;
      cnt       <= '0;
      mn        <= 16'hFFFF;
      mx        <= '0;
      over_cnt  <= '0;
      under_cnt <= '0;
      p2p       <= '0;
      p2p_valid <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      e         <= {e[2:0], en};
      p2p_valid <= 1'b0;
      if (clr) begin
        cnt       <= '0;
        mn        <= 16'hFFFF;
        mx        <= '0;
        over_cnt  <= '0;
        under_cnt <= '0;
        alarm     <= 1'b0;
      end else if (strobe) begin
        if (last) begin
          cnt       <= '0;
          mn        <= 16'hFFFF;
          mx        <= '0;
          p2p       <= p;
          p2p_valid <= 1'b1;
          if (p > THRESH) begin
            over_cnt  <= over_nxt;
            under_cnt <= '0;
            if (over_nxt >= HOLD4) alarm <= 1'b1;
          end else begin
            under_cnt <= under_nxt;
            over_cnt  <= '0;
            if (under_nxt >= CLR4) alarm <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
          mn  <= lo;
          mx  <= hi;
        end
      end
    end
  end
endmodule

module vibrate_p2p_detect #(
  parameter int          WIN_LEN  = 64,
  parameter logic [15:0] THRESH   = 16'd200,
  parameter int          HOLD_CNT = 3,
  parameter int          CLR_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] AData0,
  input  logic [15:0] AData1,
  input  logic [15:0] AData2,
  input  logic [15:0] AData3,
  input  logic        AData0_en,
  input  logic        AData1_en,
  input  logic        AData2_en,
  input  logic        AData3_en,
  output logic [15:0] P2P0,
  output logic [15:0] P2P1,
  output logic [15:0] P2P2,
  output logic [15:0] P2P3,
  output logic [3:0]  P2P_valid,
  output logic [3:0]  alarm,
  output logic        alarm_any
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][15:0] adata, p2p;
  logic [NUM_LANES-1:0]       aen;

  assign adata = {AData3, AData2, AData1, AData0};
  assign aen   = {AData3_en, AData2_en, AData1_en, AData0_en};
  assign P2P0  = p2p[0];
  assign P2P1  = p2p[1];
  assign P2P2  = p2p[2];
  assign P2P3  = p2p[3];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vibrate_p2p_lane #(
      .WIN_LEN (WIN_LEN),
      .THRESH  (THRESH),
      .HOLD_CNT(HOLD_CNT),
      .CLR_CNT (CLR_CNT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (aen[i]),
      .din      (adata[i]),
      .p2p      (p2p[i]),
      .p2p_valid(P2P_valid[i]),
      .alarm    (alarm[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_any <= 1'b0;
    else     alarm_any <= |alarm;
  end
endmodule

// File: tb/tb_vibrate_p2p_detect.sv
// Directed test-plan scenarios plus randomized traffic, checked each cycle
// against a window/queue model of the detector.

module tb_vibrate_p2p_detect;
  localparam int          WL = 4;
  localparam logic [15:0] TH = 16'd100;
  localparam int          HC = 2;
  localparam int          CC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] ad [4];
  logic [3:0]  en = '0;
  logic [15:0] P2P0, P2P1, P2P2, P2P3;
  logic [3:0]  P2P_valid, alarm;
  logic        alarm_any;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vibrate_p2p_detect #(.WIN_LEN(WL), .THRESH(TH), .HOLD_CNT(HC), .CLR_CNT(CC)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .AData0(ad[0]), .AData1(ad[1]), .AData2(ad[2]), .AData3(ad[3]),
    .AData0_en(en[0]), .AData1_en(en[1]), .AData2_en(en[2]), .AData3_en(en[3]),
    .P2P0(P2P0), .P2P1(P2P1), .P2P2(P2P2), .P2P3(P2P3),
    .P2P_valid(P2P_valid), .alarm(alarm), .alarm_any(alarm_any)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          hist [4][4];   // hist[ch][k] = enable seen k+1 edges ago
  int          win  [4][$];
  logic [15:0] m_p2p [4];
  logic [3:0]  m_vld, m_alarm;
  logic        m_any;
  int          m_over [4], m_under [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld = '0; m_alarm = '0; m_any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_p2p[c] = '0; m_over[c] = 0; m_under[c] = 0;
        win[c].delete();
        for (int k = 0; k < 4; k++) hist[c][k] = 0;
      end
    end else begin
      m_any = |m_alarm;
      m_vld = '0;
      for (int c = 0; c < 4; c++) begin
        bit stb;
        stb = (hist[c][2] == 1) && (hist[c][3] == 0);
        for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = int'(en[c]);
        if (clr) begin
          win[c].delete();
          m_over[c] = 0; m_under[c] = 0; m_alarm[c] = 1'b0;
        end else if (stb) begin
          win[c].push_back(ad[c]);
          if (win[c].size() == WL) begin
            int mx, mn, p;
            mx = 0; mn = 65535;
            foreach (win[c][i]) begin
              if (int'(win[c][i]) > mx) mx = int'(win[c][i]);
              if (int'(win[c][i]) < mn) mn = int'(win[c][i]);
            end
            p = mx - mn;
            m_p2p[c] = 16'(p);
            m_vld[c] = 1'b1;
            if (p > int'(TH)) begin
              m_over[c] = (m_over[c] < 15) ? m_over[c] + 1 : 15;
              m_under[c] = 0;
              if (m_over[c] >= HC) m_alarm[c] = 1'b1;
            end else begin
              m_under[c] = (m_under[c] < 15) ? m_under[c] + 1 : 15;
              m_over[c] = 0;
              if (m_under[c] >= CC) m_alarm[c] = 1'b0;
            end
            win[c].delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("p2p0", 32'(P2P0), 32'(m_p2p[0]));
      chk("p2p1", 32'(P2P1), 32'(m_p2p[1]));
      chk("p2p2", 32'(P2P2), 32'(m_p2p[2]));
      chk("p2p3", 32'(P2P3), 32'(m_p2p[3]));
      chk("p2p_valid", 32'(P2P_valid), 32'(m_vld));
      chk("alarm", 32'(alarm), 32'(m_alarm));
      chk("alarm_any", 32'(alarm_any), 32'(m_any));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int ch, input logic [15:0] v);
    ad[ch] = v; en[ch] = 1'b1;
    step();
    en[ch] = 1'b0;
    repeat (5) step();
  endtask

  task automatic window(input int ch, input logic [15:0] a, b, c, d);
    pulse(ch, a); pulse(ch, b); pulse(ch, c); pulse(ch, d);
  endtask

  initial begin
    int          since [4];
    bit          loud  [4];
    logic [15:0] base  [4];
    for (int c = 0; c < 4; c++) begin ad[c] = '0; since[c] = 10; loud[c] = 0; base[c] = 16'd1000; end
    repeat (2) step();
    chk("reset_p2p0", 32'(P2P0), 0);
    chk("reset_valid", 32'(P2P_valid), 0);
    chk("reset_alarm", 32'({alarm_any, alarm}), 0);
    rst = 1'b0;
    step();

    window(0, 16'd500, 16'd450, 16'd620, 16'd480);
    chk("basic_p2p0", 32'(P2P0), 170);

    window(1, 16'd100, 16'd250, 16'd100, 16'd100);
    chk("alarm1_w1", 32'(alarm[1]), 0);
    window(1, 16'd100, 16'd250, 16'd100, 16'd100);
    chk("alarm1_w2", 32'(alarm[1]), 1);
    chk("alarm_any_set", 32'(alarm_any), 1);

    window(2, 16'd0, 16'd150, 16'd0, 16'd0);
    window(2, 16'd0, 16'd150, 16'd0, 16'd0);
    chk("alarm2_set", 32'(alarm[2]), 1);
    window(2, 16'd0, 16'd100, 16'd0, 16'd0);
    chk("hyst_eq_thresh", 32'(alarm[2]), 1);
    window(2, 16'd0, 16'd300, 16'd0, 16'd0);
    chk("hyst_over", 32'(alarm[2]), 1);
    window(2, 16'd0, 16'd50, 16'd0, 16'd0);
    chk("hyst_under1", 32'(alarm[2]), 1);
    window(2, 16'd0, 16'd20, 16'd0, 16'd0);
    chk("hyst_clear", 32'(alarm[2]), 0);

    window(3, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF);
    chk("extreme_p2p3", 32'(P2P3), 65535);
    window(3, 16'd1234, 16'd1234, 16'd1234, 16'd1234);
    chk("const_p2p3", 32'(P2P3), 0);

    // clr lands on the edge that would capture ch0's third sample
    pulse(0, 16'd600); pulse(0, 16'd640);
    ad[0] = 16'd700; en[0] = 1'b1;
    step(); en[0] = 1'b0;
    step();
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    chk("clr_valid", 32'(P2P_valid[0]), 0);
    repeat (3) step();
    chk("clr_hold_p2p0", 32'(P2P0), 170);
    window(0, 16'd10, 16'd20, 16'd300, 16'd5);
    chk("clr_next_window", 32'(P2P0), 295);

    // asynchronous reset between edges, partway through a window
    window(1, 16'd0, 16'd200, 16'd0, 16'd0);
    pulse(0, 16'd900); pulse(0, 16'd50);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_p2p0", 32'(P2P0), 0);
    chk("arst_p2p1", 32'(P2P1), 0);
    chk("arst_alarm", 32'({alarm_any, alarm}), 0);
    #2 rst = 1'b0;
    step();
    window(0, 16'd7, 16'd3, 16'd9, 16'd1);
    chk("arst_next_window", 32'(P2P0), 8);

    // randomized traffic on all channels
    for (int cyc = 0; cyc < 6000; cyc++) begin
      step();
      clr = ($urandom_range(0, 150) == 0);
      for (int c = 0; c < 4; c++) begin
        if (cyc % 200 == 0) begin
          loud[c] = $urandom_range(0, 1) == 1;
          base[c] = 16'($urandom_range(0, 60000));
        end
        since[c]++;
        if (en[c]) begin
          if ($urandom_range(0, 1) == 0) en[c] = 1'b0;
        end else if (since[c] >= 4 && $urandom_range(0, 2) == 0) begin
          en[c] = 1'b1; since[c] = 0;
        end
        case ($urandom_range(0, 40))
          0:       ad[c] = 16'h0000;
          1:       ad[c] = 16'hFFFF;
          default: ad[c] = base[c] + 16'($urandom_range(0, loud[c] ? 400 : 80));
        endcase
      end
    end
    clr = 1'b0; en = '0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
